mod_reduce_sched: RTL and testbench

Shares one 256-bit modular-reduction pipeline (5-stage conditional-subtract reducer, mod p, no valid/stall) between NUM_REQ requesters. The scheduler does three things:
- Picks at most one 261-bit operand per cycle by round-robin and drives it into the pipeline.
- Tracks the requester id of each in-flight operand with a valid/tag shift register aligned to the pipeline latency.
- Catches results in a credit-protected FIFO so the non-stallable pipeline never loses data under response backpressure.

---
 rtl/mod_reduce_sched.sv | 178 +++++++++++++++++
 tb/tb_mod_reduce_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_sched.sv
// Round-robin scheduler sharing one non-stallable mod-p reduction pipeline between requesters.
// Optional statistics counters are compiled in when SCHED_STATS_EN is defined.
module mod_reduce_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned PIPE_LAT   = 5,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*261-1:0]   req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [260:0]             pipe_x,
    input  logic [255:0]             pipe_o,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [255:0]             rsp_data,
    output logic [ID_W-1:0]          rsp_id
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_stall
`endif
);

    localparam int unsigned X_W   = 261;
    localparam int unsigned D_W   = 256;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant;
    logic             any_valid;
    logic             issue;
    logic             pop;
    logic             full;
    logic [OCC_W-1:0] occ;

    logic [PIPE_LAT-1:0] tag_v;
    logic [ID_W-1:0]     tag_id [PIPE_LAT];

    logic             cap_v;
    logic [D_W-1:0]   cap_data;
    logic [ID_W-1:0]  cap_id;

    logic [D_W-1:0]   mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]  mem_id   [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W-1:0] rd_idx;
    logic [D_W-1:0]   hold_data;
    logic [ID_W-1:0]  hold_id;

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        logic [ID_W-1:0] idx;
        logic            found;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign any_valid = |req_valid;
    // Credit check: every issued operand owns a FIFO slot until it is consumed.
    assign issue     = reset && any_valid && (occ < OCC_W'(FIFO_DEPTH));
    assign req_ready = issue ? (NUM_REQ'(1) << grant) : '0;

    always_comb begin
        pipe_x = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (issue && (grant == ID_W'(i))) begin
                pipe_x = req_data[i*X_W +: X_W];
            end
        end
    end

    assign rd_idx    = rd_ptr[PTR_W-1:0];
    assign rsp_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop       = rsp_valid && rsp_ready;
    // Show-ahead head; the last popped entry is held while empty.
    assign rsp_data  = rsp_valid ? mem_data[rd_idx] : hold_data;
    assign rsp_id    = rsp_valid ? mem_id[rd_idx]   : hold_id;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (issue) begin
                rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
            end
            if (issue && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (!issue && pop) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // Tag pipe mirrors the reducer; the capture stage aligns pipe_o with its tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v    <= '0;
            cap_v    <= 1'b0;
            cap_data <= '0;
            cap_id   <= '0;
            for (int unsigned k = 0; k < PIPE_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[PIPE_LAT-2:0], issue};
            tag_id[0] <= grant;
            for (int unsigned k = 1; k < PIPE_LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
            cap_v <= tag_v[PIPE_LAT-1];
            if (tag_v[PIPE_LAT-1]) begin
                cap_data <= pipe_o;
                cap_id   <= tag_id[PIPE_LAT-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_v) begin
            mem_data[wr_ptr[PTR_W-1:0]] <= cap_data;
            mem_id[wr_ptr[PTR_W-1:0]]   <= cap_id;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold_data <= '0;
            hold_id   <= '0;
        end else begin
            if (cap_v) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + (PTR_W+1)'(1);
                hold_data <= mem_data[rd_idx];
                hold_id   <= mem_id[rd_idx];
            end
        end
    end

    // A write into a full FIFO without a simultaneous read would lose a result.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(cap_v && full && !pop));

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue && (stat_issued != '1)) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (any_valid && (occ == OCC_W'(FIFO_DEPTH)) && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mod_reduce_sched.sv
// Directed bench for mod_reduce_sched with a behavioural 5-stage mod-p reducer (p = 2^255-19).
module tb_mod_reduce_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned XW = 261;
    localparam logic [260:0] P   = (261'(1) << 255) - 261'd19;
    localparam logic [260:0] P2  = P << 1;
    localparam logic [260:0] P4  = P << 2;
    localparam logic [260:0] P8  = P << 3;
    localparam logic [260:0] P16 = P << 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [NR-1:0]      req_valid;
    logic [NR*XW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic [260:0]       pipe_x;
    logic [255:0]       pipe_o;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [255:0]       rsp_data;
    logic [1:0]         rsp_id;
`ifdef SCHED_STATS_EN
    logic [31:0]        stat_issued;
    logic [31:0]        stat_stall;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]   id;
        logic [255:0] data;
    } exp_t;
    exp_t expq[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mod_reduce_sched #(.NUM_REQ(4), .ID_W(2), .PIPE_LAT(5), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .pipe_x    (pipe_x),
        .pipe_o    (pipe_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef SCHED_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    function automatic logic [260:0] csub(input logic [260:0] x, input logic [260:0] m);
        return (x >= m) ? x - m : x;
    endfunction

    // External reducer: five conditional-subtract stages, not reset.
    logic [260:0] rs0 = '0, rs1 = '0, rs2 = '0, rs3 = '0, rs4 = '0;
    always @(posedge clk) begin
        rs0 <= csub(pipe_x, P16);
        rs1 <= csub(rs0, P8);
        rs2 <= csub(rs1, P4);
        rs3 <= csub(rs2, P2);
        rs4 <= csub(rs3, P);
    end
    assign pipe_o = rs4[255:0];

    task automatic check(input string tag, input logic [260:0] got, input logic [260:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [260:0] x);
        req_data[i*XW +: XW] = x;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [255:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        expq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        expq.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 60 && expq.size() != 0; c++) @(negedge clk);
        check(tag, 261'(expq.size()), 261'(0));
    endtask

    // Response scoreboard, sampled just before the handshake edge.
    always @(negedge clk) begin
        #3;
        if (reset && rsp_valid && rsp_ready) begin
            check("exp_avail", 261'(expq.size() != 0), 261'(1));
            if (expq.size() != 0) begin
                mon_e = expq.pop_front();
                check("rsp_data", 261'(rsp_data), 261'(mon_e.data));
                check("rsp_id", 261'(rsp_id), 261'(mon_e.id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        check("rst_req_ready", 261'(req_ready), 261'(0));
        check("rst_pipe_x", pipe_x, 261'(0));
        check("rst_rsp_valid", 261'(rsp_valid), 261'(0));
        check("rst_rsp_data", 261'(rsp_data), 261'(0));
        check("rst_rsp_id", 261'(rsp_id), 261'(0));
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b1;
        rsp_ready = 1'b1;

        // Single operand latency: 2p+5 from requester 1.
        @(negedge clk);
        req_valid = 4'b0010;
        set_data(1, P2 + 261'd5);
        #1;
        check("t1_ready", 261'(req_ready), 261'(4'b0010));
        check("t1_pipe_x", pipe_x, P2 + 261'd5);
        push_exp(2'd1, 256'd5);
        @(negedge clk);
        req_valid = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            if (k == 5) check("t1_early", 261'(rsp_valid), 261'(0));
            if (k == 6) begin
                check("t1_valid", 261'(rsp_valid), 261'(1));
                check("t1_data", 261'(rsp_data), 261'(5));
                check("t1_id", 261'(rsp_id), 261'(1));
            end
        end
        @(negedge clk);
        #1;
        check("t1_empty", 261'(rsp_valid), 261'(0));
        check("t1_hold_data", 261'(rsp_data), 261'(5));
        check("t1_hold_id", 261'(rsp_id), 261'(1));

        // Round robin with all requesters valid.
        do_reset();
        for (int i = 0; i < 4; i++) set_data(i, 261'(i) * P + 261'(100 + i));
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("rr_grant", 261'(req_ready), 261'(4'b0001 << (c % 4)));
            push_exp(2'(c % 4), 256'(((c < 4) ? 100 : 200) + (c % 4)));
            @(negedge clk);
            set_data(c % 4, 261'(c % 4) * P + 261'(200 + (c % 4)));
        end
        req_valid = '0;
        wait_drain("rr_drain");

        // Backpressure: 8 credits, then 20 stalled cycles.
        do_reset();
        rsp_ready = 1'b0;
        set_data(0, P + 261'd300);
        req_valid = 4'b0001;
        for (int c = 0; c < 28; c++) begin
            #1;
            check("bp_ready", 261'(req_ready), 261'((c < 8) ? 1 : 0));
            if (c < 8) push_exp(2'd0, 256'(300 + c));
            @(negedge clk);
            if (c < 8) set_data(0, P + 261'(301 + c));
        end
        check("bp_full_valid", 261'(rsp_valid), 261'(1));
`ifdef SCHED_STATS_EN
        check("stat_issued", 261'(stat_issued), 261'(8));
        check("stat_stall", 261'(stat_stall), 261'(20));
`endif
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check("bp_no_bubble", 261'(rsp_valid), 261'(1));
            check("bp_resume", 261'(req_ready), 261'((c == 0) ? 0 : 1));
            if (c >= 1) push_exp(2'd0, 256'(307 + c));
            @(negedge clk);
            if (c >= 1) set_data(0, P + 261'(308 + c));
        end
        req_valid = '0;
        wait_drain("bp_drain");

        // Reset while three operands are in flight.
        set_data(2, P2 + 261'd77);
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("mid_ready", 261'(req_ready), 261'(4'b0100));
            @(negedge clk);
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expq.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check("mid_quiet", 261'(rsp_valid), 261'(0));
        end
        @(negedge clk);
        set_data(3, P * 261'd3 + 261'd42);
        req_valid = 4'b1000;
        #1;
        check("mid_new_ready", 261'(req_ready), 261'(4'b1000));
        push_exp(2'd3, 256'd42);
        @(negedge clk);
        req_valid = '0;
        wait_drain("mid_drain");

        // Boundary operands issued back to back.
        @(negedge clk);
        req_valid = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            logic [260:0] x;
            logic [255:0] r;
            case (c)
                0: begin x = P - 261'd1;        r = 256'(P - 261'd1); end
                1: begin x = '0;                r = '0;               end
                2: begin x = P8 + P4;           r = '0;               end
                default: begin x = P16 + P8 + P4 + P2 + P + 261'd9; r = 256'd9; end
            endcase
            set_data(1, x);
            #1;
            check("b2b_ready", 261'(req_ready), 261'(4'b0010));
            push_exp(2'd1, r);
            @(negedge clk);
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("b2b_valid", 261'(rsp_valid), 261'(1));
        end
        @(negedge clk);
        #1;
        check("b2b_after", 261'(rsp_valid), 261'(0));
        wait_drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
